debounced_button_array: RTL and testbench

- Multi-channel successor to the single debounced button: CHANNELS independent push-buttons, each with internal pull-up, 2-FF synchroniser and debounce counter.
- Produces per channel:
  - a debounced pressed level;
  - one-cycle press and release strobes;
  - a long-press strobe.
- Sits between raw button pads and UI/control logic on iCE40 designs.

---
 rtl/debounced_button_array_if.sv | 14 +
 rtl/debounced_button_array.sv | 151 +++++++++++++++
 tb/tb_debounced_button_array.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounced_button_array_if.sv
// Pin/strobe bundle for debounced_button_array: raw active-low pins in, debounced
// level plus press/release/long-press strobes out, one bit per channel.
interface debounced_button_array_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] pressed;
    logic [CHANNELS-1:0] released;
    logic [CHANNELS-1:0] longpress;

    modport master (output in, input level, pressed, released, longpress);
    modport slave  (input in, output level, pressed, released, longpress);
endinterface

// File: rtl/debounced_button_array.sv
// Per-channel 2-FF synchroniser, debounce counter, long-press detector and optional
// auto-repeat (enabled by defining DEBOUNCED_BUTTON_ARRAY_AUTOREPEAT_EN).
module debounced_button_array #(
    parameter int CHANNELS         = 4,
    parameter int DEBOUNCE_CYCLES  = 100,
    parameter int LONGPRESS_CYCLES = 1000000,
    parameter int REPEAT_CYCLES    = 200000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    debounced_button_array_if.slave  bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HW = (LONGPRESS_CYCLES > 0) ? $clog2(LONGPRESS_CYCLES + 1) : 1;

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || LONGPRESS_CYCLES < 0 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("debounced_button_array: illegal parameter combination");
    end

    // Reset asserts asynchronously, releases two edges later in step with clk.
    logic rst_meta_q, rst_sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic [CHANNELS-1:0] level_vec, pressed_vec, released_vec, long_vec;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic          sync1_q, sync2_q;
        logic          sampled;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          pressed_q, pressed_d;
        logic          released_q, released_d;
        logic          long_q, long_d;
        logic          rep_pulse;

        // Pins idle high through the pull-up; a low pin is a press.
        assign sampled = ~sync2_q;

        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            if (sampled == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sampled;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (LONGPRESS_CYCLES > 0) begin : g_hold
            logic [HW-1:0] hold_q, hold_d;
            logic          lp_d;

            // Count only while held before and after this edge, so a release on
            // the saturating edge suppresses the long-press strobe.
            always_comb begin
                hold_d = '0;
                lp_d   = 1'b0;
                if (level_q && level_d) begin
                    if (hold_q != HW'(LONGPRESS_CYCLES)) begin
                        hold_d = hold_q + 1'b1;
                        lp_d   = (hold_q == HW'(LONGPRESS_CYCLES - 1));
                    end else begin
                        hold_d = hold_q;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_sync_q) begin
                if (!rst_sync_q) hold_q <= '0;
                else             hold_q <= hold_d;
            end

            assign long_d = lp_d;

`ifdef DEBOUNCED_BUTTON_ARRAY_AUTOREPEAT_EN
            localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
            logic [RW-1:0] rep_q, rep_d;
            logic          rep_pulse_d;

            // Runs only once the hold counter has saturated, i.e. after long-press.
            always_comb begin
                rep_d       = '0;
                rep_pulse_d = 1'b0;
                if (level_q && level_d && hold_q == HW'(LONGPRESS_CYCLES)) begin
                    if (rep_q == RW'(REPEAT_CYCLES - 1)) begin
                        rep_pulse_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_sync_q) begin
                if (!rst_sync_q) rep_q <= '0;
                else             rep_q <= rep_d;
            end

            assign rep_pulse = rep_pulse_d;
`else
            assign rep_pulse = 1'b0;
`endif
        end else begin : g_no_hold
            assign long_d    = 1'b0;
            assign rep_pulse = 1'b0;
        end

        assign pressed_d  = (level_d & ~level_q) | rep_pulse;
        assign released_d = level_q & ~level_d;

        always_ff @(posedge clk or negedge rst_sync_q) begin
            if (!rst_sync_q) begin
                sync1_q    <= 1'b1;
                sync2_q    <= 1'b1;
                cnt_q      <= '0;
                level_q    <= 1'b0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
                long_q     <= 1'b0;
            end else begin
                sync1_q    <= bus.in[gi];
                sync2_q    <= sync1_q;
                cnt_q      <= cnt_d;
                level_q    <= level_d;
                pressed_q  <= pressed_d;
                released_q <= released_d;
                long_q     <= long_d;
            end
        end

        assign level_vec[gi]    = level_q;
        assign pressed_vec[gi]  = pressed_q;
        assign released_vec[gi] = released_q;
        assign long_vec[gi]     = long_q;
    end

    assign bus.level     = level_vec;
    assign bus.pressed   = pressed_vec;
    assign bus.released  = released_vec;
    assign bus.longpress = long_vec;
endmodule

// File: tb/tb_debounced_button_array.sv
// Bench for debounced_button_array: directed scenarios plus random pin activity,
// all checked against an edge-by-edge window/age reference model.
module tb_debounced_button_array;
    localparam int CH = 2;
    localparam int D  = 4;
    localparam int L  = 10;
    localparam int R  = 3;

    logic clk;
    logic rst_n;
    logic [CH-1:0] pins;
    int total;
    int bad;

    debounced_button_array_if #(.CHANNELS(CH)) bus ();
    assign bus.in = pins;

    debounced_button_array #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(D), .LONGPRESS_CYCLES(L), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level flips once the last D synchronised samples all
    // disagree with it; age counts held edges since the press strobe.
    bit [CH-1:0] m_level, m_pressed, m_released, m_long;
    bit [1:0]    m_pipe [CH];
    bit [D-1:0]  m_win  [CH];
    int          m_valid[CH];
    int          m_age  [CH];
    int          m_edges;

    task automatic model_clear();
        m_level = '0; m_pressed = '0; m_released = '0; m_long = '0;
        m_edges = 0;
        for (int c = 0; c < CH; c++) begin
            m_pipe[c] = 2'b11; m_win[c] = '0; m_valid[c] = 0; m_age[c] = 0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_clear();
            return;
        end
        m_edges++;
        m_pressed = '0; m_released = '0; m_long = '0;
        if (m_edges < 3) return;
        for (int c = 0; c < CH; c++) begin
            bit s, prev;
            s = !m_pipe[c][1];
            m_pipe[c] = {m_pipe[c][0], pins[c]};
            m_win[c] = {m_win[c][D-2:0], s};
            if (m_valid[c] < D) m_valid[c]++;
            prev = m_level[c];
            if (m_valid[c] >= D && m_win[c] == (prev ? {D{1'b0}} : {D{1'b1}})) begin
                m_level[c] = !prev;
                m_valid[c] = 0;
            end
            m_pressed[c]  = m_level[c] & !prev;
            m_released[c] = !m_level[c] & prev;
            if (prev && m_level[c]) begin
                m_age[c]++;
                if (m_age[c] == L) m_long[c] = 1'b1;
`ifdef DEBOUNCED_BUTTON_ARRAY_AUTOREPEAT_EN
                if (m_age[c] > L && (m_age[c] - L) % R == 0) m_pressed[c] = 1'b1;
`endif
            end else begin
                m_age[c] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pins = '1; model_clear();
        repeat (3) tick();
        total++;
        if ({bus.level, bus.pressed, bus.released, bus.longpress} !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold: got %h want 00", {bus.level, bus.pressed, bus.released, bus.longpress});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({bus.level, bus.pressed, bus.released, bus.longpress} !== 8'h00) begin
                bad++;
                $display("FAIL idle cycle %0d: got %h want 00", i, {bus.level, bus.pressed, bus.released, bus.longpress});
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_press_release();
        int n;
        pins[0] = 1'b0;
        n = 0;
        do begin
            tick(); n++;
            total++;
            if ({bus.level, bus.pressed, bus.released, bus.longpress} !== {m_level, m_pressed, m_released, m_long}) begin
                bad++;
                $display("FAIL press model tick %0d: got %h want %h", n, {bus.level, bus.pressed, bus.released, bus.longpress}, {m_level, m_pressed, m_released, m_long});
            end
        end while (!bus.pressed[0] && n < 30);
        total++;
        if (n !== D + 2 || bus.level[0] !== 1'b1) begin
            bad++;
            $display("FAIL press_latency: got %0d level %b want %0d level 1", n, bus.level[0], D + 2);
        end
        tick();
        total++;
        if (bus.pressed[0] !== 1'b0) begin
            bad++;
            $display("FAIL press_one_cycle: got %b want 0", bus.pressed[0]);
        end
        pins[0] = 1'b1;
        n = 0;
        do begin
            tick(); n++;
        end while (!bus.released[0] && n < 30);
        total++;
        if (n !== D + 2 || bus.level[0] !== 1'b0 || bus.pressed !== 2'b00) begin
            bad++;
            $display("FAIL release_latency: got %0d level %b pressed %b want %0d level 0", n, bus.level[0], bus.pressed, D + 2);
        end
        repeat (3) tick();
        $display("test_press_release done");
    endtask

    task automatic test_bounce();
        bit [10:0] pat;
        bit seen;
        pat = 11'b11110001000;   // bit 0 first: low 3, high 1, low 3, then high
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            pins[1] = (i < 11) ? pat[i] : 1'b1;
            tick();
            if (bus.level[1] || bus.pressed[1] || bus.released[1] || bus.longpress[1]) seen = 1'b1;
            total++;
            if ({bus.level, bus.pressed, bus.released, bus.longpress} !== {m_level, m_pressed, m_released, m_long}) begin
                bad++;
                $display("FAIL bounce model tick %0d: got %h want %h", i, {bus.level, bus.pressed, bus.released, bus.longpress}, {m_level, m_pressed, m_released, m_long});
            end
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL bounce_reject: activity %b want 0", seen);
        end
        $display("test_bounce done");
    endtask

    task automatic test_longpress();
        int n, lp_at, lp_cnt, rep_cnt, want_rep;
        pins[0] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!bus.pressed[0] && n < 30);
        lp_at = -1; lp_cnt = 0; rep_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (bus.longpress[0]) begin lp_at = k; lp_cnt++; end
            if (bus.pressed[0]) rep_cnt++;
            total++;
            if ({bus.level, bus.pressed, bus.released, bus.longpress} !== {m_level, m_pressed, m_released, m_long}) begin
                bad++;
                $display("FAIL hold model +%0d: got %h want %h", k, {bus.level, bus.pressed, bus.released, bus.longpress}, {m_level, m_pressed, m_released, m_long});
            end
        end
`ifdef DEBOUNCED_BUTTON_ARRAY_AUTOREPEAT_EN
        want_rep = 6;
`else
        want_rep = 0;
`endif
        total++;
        if (lp_at !== L || lp_cnt !== 1) begin
            bad++;
            $display("FAIL longpress_timing: at +%0d count %0d want +%0d count 1", lp_at, lp_cnt, L);
        end
        total++;
        if (rep_cnt !== want_rep) begin
            bad++;
            $display("FAIL repeat_count: got %0d want %0d", rep_cnt, want_rep);
        end
        pins[0] = 1'b1;
        repeat (D + 4) tick();
        $display("test_longpress done");
    endtask

    task automatic test_simultaneous();
        int n;
        pins = 2'b00;
        n = 0;
        do begin tick(); n++; end while (bus.pressed === 2'b00 && n < 30);
        total++;
        if (bus.pressed !== 2'b11 || bus.level !== 2'b11) begin
            bad++;
            $display("FAIL both_press: pressed %b level %b want 11 11", bus.pressed, bus.level);
        end
        pins[1] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (bus.released === 2'b00 && n < 30);
        total++;
        if (bus.released !== 2'b10 || bus.level !== 2'b01) begin
            bad++;
            $display("FAIL ch1_release: released %b level %b want 10 01", bus.released, bus.level);
        end
        pins = 2'b11;
        repeat (D + 4) tick();
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid();
        int n;
        pins[0] = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0; model_clear(); #1;
        total++;
        if ({bus.level, bus.pressed, bus.released, bus.longpress} !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_debounce: got %h want 00", {bus.level, bus.pressed, bus.released, bus.longpress});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        // Two synchroniser edges, then capture plus D + 1 edges of debounce.
        n = 0;
        do begin tick(); n++; end while (!bus.pressed[0] && n < 40);
        total++;
        if (n !== D + 4) begin
            bad++;
            $display("FAIL press_after_reset: got %0d edges want %0d", n, D + 4);
        end
        repeat (5) tick();
        rst_n = 1'b0; model_clear(); #1;
        total++;
        if ({bus.level, bus.pressed, bus.released, bus.longpress} !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_hold: got %h want 00", {bus.level, bus.pressed, bus.released, bus.longpress});
        end
        tick();
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.pressed[0] && n < 40);
        n = 0;
        do begin
            tick(); n++;
            total++;
            if ({bus.level, bus.pressed, bus.released, bus.longpress} !== {m_level, m_pressed, m_released, m_long}) begin
                bad++;
                $display("FAIL rehold model +%0d: got %h want %h", n, {bus.level, bus.pressed, bus.released, bus.longpress}, {m_level, m_pressed, m_released, m_long});
            end
        end while (!bus.longpress[0] && n < 40);
        total++;
        if (n !== L) begin
            bad++;
            $display("FAIL longpress_after_reset: got +%0d want +%0d", n, L);
        end
        pins[0] = 1'b1;
        repeat (D + 4) tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int run[CH];
        for (int c = 0; c < CH; c++) run[c] = $urandom_range(1, 8);
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH; c++) begin
                run[c]--;
                if (run[c] <= 0) begin
                    pins[c] = ~pins[c];
                    run[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 6);
                end
            end
            tick();
            total++;
            if ({bus.level, bus.pressed, bus.released, bus.longpress} !== {m_level, m_pressed, m_released, m_long}) begin
                bad++;
                $display("FAIL random tick %0d: got %h want %h", i, {bus.level, bus.pressed, bus.released, bus.longpress}, {m_level, m_pressed, m_released, m_long});
            end
        end
        pins = 2'b11;
        repeat (D + 4) tick();
        $display("test_random done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        pins  = '1;
        rst_n = 1'b0;
        test_reset();
        test_press_release();
        test_bounce();
        test_longpress();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
